stage_4: RTL
============

// Module: stage_4
// PURPOSE
//  Memory-access stage of the 5-stage RV32I pipeline; consumes execute-stage results (alu_out, rs_2, rd_num, opcode, func_3, op_type).
//  Non-memory ops pass through a one-cycle pipeline register. LOAD/STORE drive a req/ack data-memory port, then format load data.
//  Stalls upstream while a memory access is outstanding. Feeds the write-back stage.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles in S_REQ without mem_ack before bus error; 0 = wait forever
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  i_valid      in   1   stage-3 outputs valid this cycle
//  i_alu_out    in   32  result, or effective address when i_op_type=1
//  i_rs_2       in   32  store data
//  i_rd_num     in   5   destination register
//  i_opcode     in   7   RV32I opcode
//  i_func_3     in   3   width/sign select for LOAD/STORE
//  i_op_type    in   1   1 = memory op (LOAD/STORE)
//  o_stall      out  1   1 = stage busy; upstream holds its outputs
//  mem_req      out  1   data-memory request
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address, {addr[31:2],2'b00}
//  mem_wdata    out  32  lane-replicated store data
//  mem_wstrb    out  4   byte enables
//  mem_ack      in   1   access complete; mem_rdata valid with it
//  mem_rdata    in   32  read word
//  wb_valid     out  1   write-back bundle valid, one-cycle pulse per instruction
//  wb_we        out  1   register-file write enable
//  wb_rd_num    out  5   destination register
//  wb_data      out  32  write-back value
//  wb_misalign  out  1   misaligned LOAD/STORE, no memory access made
//  wb_bus_err   out  1   memory timeout
// BEHAVIOUR
//  - Reset (async, rst_n=0): state S_IDLE, timeout counter 0, all outputs 0. mem_req drops immediately, mid-access included; the pending access is abandoned with no wb_valid.
//  - Accept: at a rising edge with i_valid=1 and o_stall=0. o_stall = (state != S_IDLE); combinational from state only.
//  - FSM: S_IDLE -> S_REQ on accept of an aligned LOAD/STORE.
//     S_REQ -> S_IDLE on mem_ack=1 or on timeout. Otherwise stay in S_REQ.
//  - Non-memory op, or misaligned mem op: wb_* registered at the accept edge. Latency 1; state stays S_IDLE.
//  - S_REQ: mem_req=1, mem_addr/mem_we/mem_wdata/mem_wstrb stable, all registered at the accept edge. The first mem_req cycle follows the accept edge.
//  - mem_ack is sampled at each edge in S_REQ; it may arrive in the first req cycle (minimum latency 2). At the ack edge: mem_req drops, wb_* loaded, state -> S_IDLE.
//  - mem_ack outside S_REQ is ignored.
//  - Timeout: counter clears on entering S_REQ and increments each S_REQ cycle without ack. At MEM_TIMEOUT: leave S_REQ; wb_valid=1, wb_bus_err=1, wb_we=0.
//  - Alignment (a = i_alu_out[1:0]): LH/LHU/SH need a[0]=0; LW/SW need a=0.
//     A violation gives wb_valid=1, wb_misalign=1, wb_we=0, mem_req never asserted.
//  - Store: SB wstrb=4'b0001<<a, wdata={4{rs_2[7:0]}}; SH wstrb=4'b0011<<a, wdata={2{rs_2[15:0]}}; SW wstrb=4'hF, wdata=rs_2.
//  - Load: w = mem_rdata >> (8*a).
//     LB sign-extends w[7:0]; LBU zero-extends w[7:0]; LH sign-extends w[15:0]; LHU zero-extends w[15:0]; LW = mem_rdata.
//     Load reads use mem_we=0 and mem_wstrb=0.
//  - Undefined func_3 on LOAD/STORE: treated as misaligned (wb_misalign=1).
//  - wb_we=1 only for OPIMM, OP, JAL, JALR, LUI, AUIPC and completed LOAD, and only when rd_num != 0. STORE and all other opcodes give wb_we=0.
//  - wb_data = i_alu_out for non-load ops; formatted load data for LOAD.
//  - wb_valid is a one-cycle pulse; wb_* hold their last value while wb_valid=0. Idle cycles (i_valid=0) produce wb_valid=0.
// TESTING
//  1. OPIMM, alu_out=32'h0000_002A, rd=5, i_valid=1 -> next cycle wb_valid=1, wb_we=1, wb_rd_num=5, wb_data=32'h2A, mem_req=0.
//  2. LB, addr=32'h103, mem_rdata=32'h80FF_1234, ack on 3rd req cycle -> o_stall=1 for 3 cycles; wb_data=32'hFFFF_FF80. Repeat as LBU -> 32'h0000_0080.
//  3. SH, addr=32'h202, rs_2=32'hDEAD_BEEF, ack in first req cycle -> mem_addr=32'h200, mem_wstrb=4'b1100, mem_wdata=32'hBEEF_BEEF, mem_we=1; wb_valid=1, wb_we=0.
//  4. LW, addr=32'h105 -> mem_req never asserted, wb_misalign=1, wb_we=0, o_stall stays 0.
//  5. LW, no mem_ack, MEM_TIMEOUT=16 -> mem_req high 16 cycles, then wb_bus_err=1, mem_req=0, o_stall=0.
//  6. LW outstanding, rst_n=0 mid-wait -> mem_req=0 and o_stall=0 immediately, no wb_valid; a later ack is ignored.

Source files
------------

// File: rtl/stage_4.sv
// stage_4: RV32I memory-access stage. Passes non-memory results through one register and
// runs LOAD/STORE over a req/ack data port, stalling upstream while an access is pending.
`default_nettype none

module stage_4 #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic        i_op_type,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] c_OP_OPIMM = 7'b0010011;
  localparam logic [6:0] c_OP_OP    = 7'b0110011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;
  localparam logic [6:0] c_OP_JALR  = 7'b1100111;
  localparam logic [6:0] c_OP_LUI   = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

  localparam int              CW        = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0]   c_TO_LAST = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ld;
  logic [2:0]    r_f3;
  logic [1:0]    r_a;
  logic [4:0]    r_rd;

  logic          w_accept, w_is_load, w_ok, w_rf_op, w_to;
  logic [1:0]    w_a;
  logic [3:0]    w_wstrb;
  logic [31:0]   w_wdata, w_shift, w_ld_data;

  assign o_stall   = (r_state != S_IDLE);
  assign w_accept  = i_valid && (r_state == S_IDLE);
  assign w_is_load = (i_opcode == c_OP_LOAD);
  assign w_a       = i_alu_out[1:0];
  assign w_rf_op   = (i_opcode == c_OP_OPIMM) || (i_opcode == c_OP_OP)  || (i_opcode == c_OP_JAL) ||
                     (i_opcode == c_OP_JALR)  || (i_opcode == c_OP_LUI) || (i_opcode == c_OP_AUIPC);
  assign w_to      = (MEM_TIMEOUT != 0) && (r_cnt == c_TO_LAST);

  // Undefined widths (and unsigned stores) fall out as "not ok" and report as misaligned.
  always_comb begin
    w_ok = 1'b0;
    case (i_func_3)
      3'b000:  w_ok = 1'b1;
      3'b001:  w_ok = ~w_a[0];
      3'b010:  w_ok = (w_a == 2'b00);
      3'b100:  w_ok = w_is_load;
      3'b101:  w_ok = w_is_load & ~w_a[0];
      default: w_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_wstrb = 4'h0;
    w_wdata = 32'h0;
    if (!w_is_load) begin
      case (i_func_3[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << w_a;
          w_wdata = {4{i_rs_2[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_a;
          w_wdata = {2{i_rs_2[15:0]}};
        end
        default: begin
          w_wstrb = 4'hF;
          w_wdata = i_rs_2;
        end
      endcase
    end
  end

  assign w_shift = mem_rdata >> {r_a, 3'b000};

  always_comb begin
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_ld_data = {24'h0, w_shift[7:0]};
      3'b001:  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_ld_data = {16'h0, w_shift[15:0]};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ld        <= 1'b0;
      r_f3        <= 3'h0;
      r_a         <= 2'h0;
      r_rd        <= 5'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd_num   <= 5'h0;
      wb_data     <= 32'h0;
      wb_misalign <= 1'b0;
      wb_bus_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && i_op_type && w_ok) begin
            r_state   <= S_REQ;
            r_cnt     <= '0;
            r_ld      <= w_is_load;
            r_f3      <= i_func_3;
            r_a       <= w_a;
            r_rd      <= i_rd_num;
            mem_req   <= 1'b1;
            mem_we    <= ~w_is_load;
            mem_addr  <= {i_alu_out[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_wstrb <= w_wstrb;
          end else if (w_accept) begin
            // Any memory op reaching here failed the alignment/width check.
            wb_valid    <= 1'b1;
            wb_we       <= ~i_op_type & w_rf_op & (i_rd_num != 5'd0);
            wb_rd_num   <= i_rd_num;
            wb_data     <= i_alu_out;
            wb_misalign <= i_op_type;
            wb_bus_err  <= 1'b0;
          end
        end
        default: begin
          if (mem_ack || w_to) begin
            r_state     <= S_IDLE;
            mem_req     <= 1'b0;
            wb_valid    <= 1'b1;
            wb_we       <= mem_ack & r_ld & (r_rd != 5'd0);
            wb_rd_num   <= r_rd;
            wb_data     <= (mem_ack && r_ld) ? w_ld_data : {mem_addr[31:2], r_a};
            wb_misalign <= 1'b0;
            wb_bus_err  <= ~mem_ack;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
